pipe_stage_buffer: RTL and testbench

PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

---
 rtl/pipe_stage_buffer.sv | 147 ++++++++++++++
 tb/tb_pipe_stage_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// rtl/pipe_stage_buffer.sv - two-entry skid pipeline stage register with flush, freeze and stall counter
module pipe_stage_buffer #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 16,
  parameter int CLR_DATA = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // MAIN is the head entry seen downstream; SKID catches the entry that
  // arrives while the head is blocked.
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic [CTRL_W-1:0] w_main_ctrl_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;

  logic [15:0] r_stall_cnt;

  logic w_in_ready;
  logic w_out_valid;
  logic w_in_fire;
  logic w_out_fire;
  logic w_clr_data;

  // Handshake signals depend only on cpu_en and registered state.
  assign w_in_ready  = cpu_en & (r_state != ST_FULL);
  assign w_out_valid = cpu_en & (r_state != ST_EMPTY);
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;
  assign w_clr_data  = (CLR_DATA != 0);

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main_data;
  // A bubble must never carry live control bits downstream.
  assign out_ctrl  = w_out_valid ? r_main_ctrl : {CTRL_W{1'b0}};
  assign stall_cnt = r_stall_cnt;

  // Next-state and entry-storage decode: flush beats freeze beats handshake.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_data_nxt = r_main_data;
    w_main_ctrl_nxt = r_main_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;

    if (flush) begin
      w_state_nxt     = ST_EMPTY;
      w_main_ctrl_nxt = {CTRL_W{1'b0}};
      w_skid_ctrl_nxt = {CTRL_W{1'b0}};
      if (w_clr_data) begin
        w_main_data_nxt = {DATA_W{1'b0}};
        w_skid_data_nxt = {DATA_W{1'b0}};
      end
    end else if (cpu_en) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt     = ST_ONE;
            w_main_data_nxt = in_data;
            w_main_ctrl_nxt = in_ctrl;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_data_nxt = in_data;
            w_main_ctrl_nxt = in_ctrl;
          end else if (w_in_fire) begin
            w_state_nxt     = ST_FULL;
            w_skid_data_nxt = in_data;
            w_skid_ctrl_nxt = in_ctrl;
          end else if (w_out_fire) begin
            w_state_nxt     = ST_EMPTY;
            w_main_ctrl_nxt = {CTRL_W{1'b0}};
            if (w_clr_data) begin
              w_main_data_nxt = {DATA_W{1'b0}};
            end
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_state_nxt     = ST_ONE;
            w_main_data_nxt = r_skid_data;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_skid_data_nxt = {DATA_W{1'b0}};
            w_skid_ctrl_nxt = {CTRL_W{1'b0}};
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // State and entry registers; reset clears both entries regardless of CLR_DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main_data <= {DATA_W{1'b0}};
      r_main_ctrl <= {CTRL_W{1'b0}};
      r_skid_data <= {DATA_W{1'b0}};
      r_skid_ctrl <= {CTRL_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_main_data <= w_main_data_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
    end
  end

  // Saturating count of cycles where the head is offered but not taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb/tb_pipe_stage_buffer.sv - directed self-checking bench for pipe_stage_buffer
module tb_pipe_stage_buffer;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_ready;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [15:0] a_out_ctrl, a_stall_cnt;
  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [15:0] b_out_ctrl, b_stall_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_stage_buffer #(.DATA_W(32), .CTRL_W(16), .CLR_DATA(1)) u_dut_clr (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_ctrl(a_out_ctrl), .stall_cnt(a_stall_cnt)
  );

  pipe_stage_buffer #(.DATA_W(32), .CTRL_W(16), .CLR_DATA(0)) u_dut_hold (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_ctrl(b_out_ctrl), .stall_cnt(b_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [15:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    tick();
  endtask

  initial begin
    rst = 1'b1; cpu_en = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = 32'h0; in_ctrl = 16'h0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, a_out_valid}, 32'h0);
    chk("rst_out_data", a_out_data, 32'h0);
    chk("rst_out_data_hold", b_out_data, 32'h0);
    chk("rst_out_ctrl", {16'h0, a_out_ctrl}, 32'h0);
    chk("rst_in_ready", {31'b0, a_in_ready}, 32'h1);
    chk("rst_stall", {16'h0, a_stall_cnt}, 32'h0);
    cpu_en = 1'b0; #1;
    chk("rst_in_ready_frozen", {31'b0, a_in_ready}, 32'h0);
    cpu_en = 1'b1; #1;

    // Streaming: one entry per cycle, one cycle latency
    out_ready = 1'b1;
    push(32'd1, 16'h0001);
    chk("stream_v1", {31'b0, a_out_valid}, 32'h1);
    chk("stream_d1", a_out_data, 32'd1);
    chk("stream_c1", {16'h0, a_out_ctrl}, 32'h1);
    push(32'd2, 16'h0002);
    chk("stream_d2", a_out_data, 32'd2);
    push(32'd3, 16'h0003);
    chk("stream_d3", a_out_data, 32'd3);
    chk("stream_in_ready", {31'b0, a_in_ready}, 32'h1);
    in_valid = 1'b0;
    tick();
    chk("drain_out_valid", {31'b0, a_out_valid}, 32'h0);
    chk("drain_data_clr", a_out_data, 32'h0);
    chk("drain_data_hold", b_out_data, 32'd3);
    chk("drain_ctrl_hold", {16'h0, b_out_ctrl}, 32'h0);
    chk("stream_stall", {16'h0, a_stall_cnt}, 32'h0);

    // Backpressure into the skid entry
    out_ready = 1'b0;
    push(32'hAA, 16'h00A1);
    push(32'hBB, 16'h00B2);
    in_valid = 1'b0; #1;
    chk("bp_in_ready_full", {31'b0, a_in_ready}, 32'h0);
    chk("bp_head", a_out_data, 32'hAA);
    chk("bp_stall1", {16'h0, a_stall_cnt}, 32'h1);
    tick(); tick();
    chk("bp_stall3", {16'h0, a_stall_cnt}, 32'h3);
    out_ready = 1'b1; #1;
    chk("bp_release_head", a_out_data, 32'hAA);
    chk("bp_release_ctrl", {16'h0, a_out_ctrl}, 32'hA1);
    tick();
    chk("bp_second", a_out_data, 32'hBB);
    chk("bp_second_ctrl", {16'h0, a_out_ctrl}, 32'hB2);
    chk("bp_in_ready_back", {31'b0, a_in_ready}, 32'h1);
    chk("bp_stall_held", {16'h0, a_stall_cnt}, 32'h3);
    tick();
    chk("bp_empty", {31'b0, a_out_valid}, 32'h0);

    // Flush while FULL with a third entry offered
    out_ready = 1'b0;
    push(32'hA1, 16'h0011);
    push(32'hB1, 16'h0022);
    in_data = 32'hC1; in_ctrl = 16'h0033; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("flush_out_valid", {31'b0, a_out_valid}, 32'h0);
    chk("flush_out_ctrl", {16'h0, a_out_ctrl}, 32'h0);
    chk("flush_out_data", a_out_data, 32'h0);
    chk("flush_hold_data", b_out_data, 32'hA1);
    out_ready = 1'b1;
    tick(); tick();
    chk("flush_nothing_left", {31'b0, a_out_valid}, 32'h0);
    // Flush coinciding with an accepted entry in EMPTY discards it
    in_valid = 1'b1; in_data = 32'hC2; in_ctrl = 16'h0044; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("flush_discard_in", {31'b0, a_out_valid}, 32'h0);

    // Reset while FULL
    out_ready = 1'b0;
    push(32'h11, 16'h000F);
    push(32'h22, 16'h00F0);
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("rstmid_out_valid", {31'b0, a_out_valid}, 32'h0);
    chk("rstmid_out_data", a_out_data, 32'h0);
    chk("rstmid_out_data_hold", b_out_data, 32'h0);
    chk("rstmid_out_ctrl", {16'h0, a_out_ctrl}, 32'h0);
    chk("rstmid_stall", {16'h0, a_stall_cnt}, 32'h0);
    chk("rstmid_in_ready", {31'b0, a_in_ready}, 32'h1);
    out_ready = 1'b1;
    tick(); tick();
    chk("rstmid_no_entry", {31'b0, a_out_valid}, 32'h0);
    out_ready = 1'b0;
    push(32'h77, 16'h003C);
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    chk("hold_flush_ctrl", {16'h0, b_out_ctrl}, 32'h0);
    chk("hold_flush_valid", {31'b0, b_out_valid}, 32'h0);
    chk("hold_flush_data", b_out_data, 32'h77);
    chk("clr_flush_data", a_out_data, 32'h0);
    chk("flush_stall", {16'h0, a_stall_cnt}, 32'h0);

    // Freeze with ONE holding 0x55
    out_ready = 1'b0;
    push(32'h55, 16'h0005);
    in_data = 32'h66; in_ctrl = 16'h0006; in_valid = 1'b1; cpu_en = 1'b0; #1;
    chk("frz_in_ready", {31'b0, a_in_ready}, 32'h0);
    chk("frz_out_valid", {31'b0, a_out_valid}, 32'h0);
    chk("frz_out_ctrl", {16'h0, a_out_ctrl}, 32'h0);
    tick(); tick(); tick();
    chk("frz_stall", {16'h0, a_stall_cnt}, 32'h0);
    cpu_en = 1'b1; in_valid = 1'b0; #1;
    chk("frz_resume_valid", {31'b0, a_out_valid}, 32'h1);
    chk("frz_resume_data", a_out_data, 32'h55);
    chk("frz_resume_ctrl", {16'h0, a_out_ctrl}, 32'h5);
    out_ready = 1'b1;
    tick();
    chk("frz_no_extra", {31'b0, a_out_valid}, 32'h0);

    // Saturation of the stall counter
    out_ready = 1'b0;
    push(32'h99, 16'h0009);
    in_valid = 1'b0;
    repeat (65534) tick();
    chk("sat_fffe", {16'h0, a_stall_cnt}, 32'hFFFE);
    tick();
    chk("sat_ffff", {16'h0, a_stall_cnt}, 32'hFFFF);
    repeat (5) tick();
    chk("sat_stays", {16'h0, a_stall_cnt}, 32'hFFFF);
    chk("sat_head", a_out_data, 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
